instr_decode_stage: RTL
=======================

// Module: instr_decode_stage
// PURPOSE
//  Registered RV32I decode stage between fetch and register-file read.
//  Splits each instruction into fields and builds the sign-extended immediate.
//  Classifies the instruction's immediate format and flags illegal encodings.
//  Decouples fetch from execute with a valid/ready handshake and an optional skid slot.
// PARAMETERS
//  XLEN   32  datapath width; imm is sign-extended to XLEN (legal: 32, 64)
//  PC_W   32  width of the PC carried alongside the instruction
//  SKID   1   1: two-entry skid buffer, registered in_ready; 0: single register
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  flush      in   1      discard all held and incoming instructions this cycle
//  in_valid   in   1      fetch presents in_instr/in_pc
//  in_ready   out  1      stage accepts input this cycle
//  in_instr   in   32     raw instruction word
//  in_pc      in   PC_W   PC of in_instr
//  out_valid  out  1      decoded instruction present
//  out_ready  in   1      downstream accepts the output
//  out_pc     out  PC_W   PC of the decoded instruction
//  op         out  7      instr[6:0]
//  rd         out  5      instr[11:7]
//  funct3     out  3      instr[14:12]
//  rs1        out  5      instr[19:15]
//  rs2        out  5      instr[24:20]
//  funct7     out  7      instr[31:25]
//  funct7b5   out  1      instr[30]
//  opb5       out  1      instr[5]
//  imm        out  XLEN   sign-extended immediate; 0 for R-type and illegal
//  imm_type   out  3      IMM_NONE=0, I=1, S=2, B=3, U=4, J=5
//  illegal    out  1      unsupported or illegal encoding
// BEHAVIOUR
//  Reset
//   - All outputs 0 while rst_n is low, including out_valid.
//   - in_ready is 1 from the first clock edge after rst_n deasserts.
//  Latency and handshakes
//   - 1 cycle from an accepted input (in_valid & in_ready) to out_valid.
//   - Full throughput: one instruction per cycle while out_ready stays 1.
//   - Output transfers on out_valid & out_ready.
//   - While out_valid & !out_ready, every output holds stable.
//   - Strict FIFO order; no drops or duplicates except on flush.
//  SKID=1
//   - in_ready is a flop: 1 when the skid slot is empty.
//   - An input accepted while the output is stalled goes into the skid slot.
//   - The skid slot drains to the output register on the next out_ready.
//  SKID=0
//   - in_ready = !out_valid | out_ready (combinational).
//  Decode, combinational on in_instr, registered on accept
//   - 0000011 load, 0010011 op-imm, 1100111 jalr, 1110011 system: I-type.
//   - 0100011: S-type.  1100011: B-type.  0110111, 0010111: U-type.
//   - 1101111: J-type.  0110011: R-type, imm_type NONE.
//   - Any other opcode, or instr[1:0] != 2'b11: illegal=1, imm=0, imm_type=NONE.
//   - instr == 32'h0 is illegal.
//   - Illegal instructions still flow with out_valid; the consumer traps.
//   - B and J immediates have bit 0 = 0.
//   - U immediate = {instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
//  Flush
//   - Clears out_valid and the skid slot at the next edge.
//   - Any in_valid input in the flush cycle is dropped.
//   - in_ready is 1 in the cycle after a flush.
//  Simultaneous events
//   - flush has priority over accept and transfer.
//   - A full output plus an accept plus out_ready in one cycle is a pass-through; the skid stays empty.
//  Reset mid-stream
//   - Held instructions are lost.
//   - Output and skid state are cleared asynchronously.
// STRUCTURE
//  - Package instr_pkg: opcode localparams, IMM_* codes, field-position constants.
//  - Sub-module imm_gen (combinational): instr -> {imm, imm_type, illegal}.
//  - One instance of imm_gen sits on the input path; results are registered with the fields.
// TESTING
//  - addi x1,x2,-1 (0xFFF10093): rd=1, rs1=2, imm=0xFFFFFFFF, imm_type=1, out_valid 1 cycle later.
//  - sw x5,8(x2) (0x00512423) -> imm=8, imm_type=2.
//  - beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, imm_type=3.
//  - lui x3,0x12345 (0x123451B7) -> imm=0x12345000, imm_type=4.
//  - 0x00000000 -> illegal=1, imm=0.
//  - Backpressure: 4 back-to-back inputs with out_ready=0 for 3 cycles.
//     - Outputs stay stable and in_ready drops once the skid is full.
//     - All 4 emerge in order with the correct PCs.
//  - Flush with output and skid full and in_valid=1.
//     - out_valid=0 next cycle; none of the 3 instructions appear; in_ready=1.
//  - XLEN=64: addi -1 -> imm=0xFFFFFFFFFFFFFFFF; lui 0x80000 -> imm=0xFFFFFFFF80000000.

Source files
------------

// File: rtl/instr_pkg.sv
// ----------------------------------------------------------------------------
// instr_pkg
//   Shared RV32I decode definitions: major opcode values, immediate-format
//   codes and the bit positions of the fixed instruction fields.
//   No ports (package).
// ----------------------------------------------------------------------------
package instr_pkg;

    // Major opcodes (instr[6:0]) recognised by the decode stage
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // Immediate format reported alongside the decoded instruction
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    // Field positions inside the 32-bit instruction word
    localparam int unsigned OP_LSB   = 0;
    localparam int unsigned RD_LSB   = 7;
    localparam int unsigned F3_LSB   = 12;
    localparam int unsigned RS1_LSB  = 15;
    localparam int unsigned RS2_LSB  = 20;
    localparam int unsigned F7_LSB   = 25;
    localparam int unsigned F7B5_BIT = 30;
    localparam int unsigned OPB5_BIT = 5;

endpackage

// File: rtl/instr_decode_stage_if.sv
// ----------------------------------------------------------------------------
// instr_decode_stage_if
//   Handshake and data bundle around the decode stage.
//   master : fetch/downstream environment (drives flush, in_*, out_ready)
//   slave  : the decode stage itself (drives in_ready, out_*, decoded fields)
//   Signals: flush, in_valid, in_ready, in_instr[31:0], in_pc[PC_W-1:0],
//            out_valid, out_ready, out_pc, op, rd, funct3, rs1, rs2, funct7,
//            funct7b5, opb5, imm[XLEN-1:0], imm_type[2:0], illegal
// ----------------------------------------------------------------------------
interface instr_decode_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      op;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic            funct7b5;
    logic            opb5;
    logic [XLEN-1:0] imm;
    logic [2:0]      imm_type;
    logic            illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, op, rd, funct3, rs1, rs2,
               funct7, funct7b5, opb5, imm, imm_type, illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, op, rd, funct3, rs1, rs2,
               funct7, funct7b5, opb5, imm, imm_type, illegal
    );
endinterface

// File: rtl/imm_gen.sv
// ----------------------------------------------------------------------------
// imm_gen
//   Combinational immediate generator / format classifier for RV32I.
//   instr    in  32    raw instruction word
//   imm      out XLEN  sign-extended immediate, 0 for R-type and illegal
//   imm_type out       immediate format (IMM_NONE for R-type and illegal)
//   illegal  out 1     opcode not supported or instr[1:0] != 2'b11
// ----------------------------------------------------------------------------
module imm_gen
    import instr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type,
    output logic            illegal
);

    logic [31:0] imm32;

    always_comb begin
        imm32    = '0;
        imm_type = IMM_NONE;
        illegal  = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (instr[6:0])
                OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
                    imm_type = IMM_I;
                    imm32    = {{20{instr[31]}}, instr[31:20]};
                end
                OP_STORE: begin
                    imm_type = IMM_S;
                    imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                end
                OP_BRANCH: begin
                    imm_type = IMM_B;
                    imm32    = {{19{instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
                end
                OP_LUI, OP_AUIPC: begin
                    imm_type = IMM_U;
                    imm32    = {instr[31:12], 12'b0};
                end
                OP_JAL: begin
                    imm_type = IMM_J;
                    imm32    = {{11{instr[31]}}, instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0};
                end
                OP_REG: begin
                    imm_type = IMM_NONE;
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

    // All formats are built as 32-bit values; a signed width cast widens to 64.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/instr_decode_stage.sv
// ----------------------------------------------------------------------------
// instr_decode_stage
//   Registered RV32I decode stage between fetch and register-file read.
//   Decodes on the input path and registers fields, immediate, format and
//   illegal flag together with the PC. Valid/ready on both sides, with an
//   optional two-entry skid buffer (SKID=1) that makes in_ready a flop.
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset
//   bus   slave side of instr_decode_stage_if (handshakes, fields, flush)
// ----------------------------------------------------------------------------
module instr_decode_stage
    import instr_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned PC_W = 32,
    parameter int unsigned SKID = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_decode_stage_if.slave   bus
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] imm;
        imm_type_e       imm_type;
        logic            illegal;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;
    logic            dec_ill;
    entry_t          in_e;
    entry_t          out_q;
    logic            out_valid_q;
    logic            in_ready_w;
    logic            accept;
    logic            stall;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr    (bus.in_instr),
        .imm      (dec_imm),
        .imm_type (dec_type),
        .illegal  (dec_ill)
    );

    always_comb begin
        in_e = '{instr: bus.in_instr, pc: bus.in_pc, imm: dec_imm,
                 imm_type: dec_type, illegal: dec_ill};
    end

    assign accept = bus.in_valid & in_ready_w;
    assign stall  = out_valid_q & ~bus.out_ready;

    generate
        if (SKID != 0) begin : g_skid
            entry_t skid_q;
            logic   skid_valid_q;
            logic   ready_q;

            // The skid slot only ever fills while the output is stalled and is
            // drained first whenever the output frees up, so it can never be
            // occupied with the output register empty.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q  <= 1'b0;
                    out_q        <= '0;
                    skid_valid_q <= 1'b0;
                    skid_q       <= '0;
                    ready_q      <= 1'b0;
                end else if (bus.flush) begin
                    out_valid_q  <= 1'b0;
                    skid_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                end else begin
                    if (!stall) begin
                        if (skid_valid_q) begin
                            out_q        <= skid_q;
                            out_valid_q  <= 1'b1;
                            skid_valid_q <= 1'b0;
                        end else if (accept) begin
                            out_q       <= in_e;
                            out_valid_q <= 1'b1;
                        end else begin
                            out_valid_q <= 1'b0;
                        end
                    end else if (accept) begin
                        skid_q       <= in_e;
                        skid_valid_q <= 1'b1;
                    end
                    // in_ready next = skid slot empty after this edge
                    ready_q <= !(stall && (skid_valid_q || accept));
                end
            end

            assign in_ready_w = ready_q;
        end else begin : g_noskid
            logic live_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    live_q <= 1'b0;
                end else begin
                    live_q <= 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid_q <= 1'b0;
                    out_q       <= '0;
                end else if (bus.flush) begin
                    out_valid_q <= 1'b0;
                end else if (accept) begin
                    out_q       <= in_e;
                    out_valid_q <= 1'b1;
                end else if (!stall) begin
                    out_valid_q <= 1'b0;
                end
            end

            assign in_ready_w = live_q & (~out_valid_q | bus.out_ready);
        end
    endgenerate

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = out_q.pc;
    assign bus.op        = out_q.instr[OP_LSB +: 7];
    assign bus.rd        = out_q.instr[RD_LSB +: 5];
    assign bus.funct3    = out_q.instr[F3_LSB +: 3];
    assign bus.rs1       = out_q.instr[RS1_LSB +: 5];
    assign bus.rs2       = out_q.instr[RS2_LSB +: 5];
    assign bus.funct7    = out_q.instr[F7_LSB +: 7];
    assign bus.funct7b5  = out_q.instr[F7B5_BIT];
    assign bus.opb5      = out_q.instr[OPB5_BIT];
    assign bus.imm       = out_q.imm;
    assign bus.imm_type  = out_q.imm_type;
    assign bus.illegal   = out_q.illegal;

endmodule
